// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-I subset core: opcodes, functs,
// ALU control codes, FSM state encoding and small decode helpers.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // True for every op/funct combination the core implements
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SYSCALL);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type funct to ALU control code
    function automatic logic [3:0] alu_ctrl_of(input logic [5:0] funct);
        logic [3:0] code;
        code = ALU_ADD;
        case (funct)
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_SLT:  code = ALU_SLT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mips_mc_core_if.sv
// Shared instruction/data memory port with req/ack handshake.
interface mips_mc_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by arithmetic, address and branch compare.
module alu
    import mips_pkg::*;
(
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result_c,
    output logic            alu_zero
);

    // Operation select; add/sub wrap, slt is signed
    always_comb begin
        result_c = '0;
        case (alu_ctrl)
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_SLT: result_c = XLEN'($signed(a) < $signed(b));
            default: result_c = '0;
        endcase
    end

    assign alu_zero = (result_c == '0);

endmodule

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 reads as zero.
module mips_mc_regfile
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RIDX-1:0] raddr_a,
    input  logic [RIDX-1:0] raddr_b,
    input  logic            we,
    input  logic [RIDX-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_a_c,
    output logic [XLEN-1:0] rdata_b_c
);

    logic [XLEN-1:0] regs [32];

    // Write port; writes to $0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-I subset core with a single shared req/ack memory port.
// Optional MIPS_MC_TRACE_EN adds a registered retire-trace port.
module mips_mc_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_mc_core_if.master        bus,
    output logic                  halted,
    output logic                  fault
`ifdef MIPS_MC_TRACE_EN
    ,
    output logic                  trc_valid,
    output logic [XLEN-1:0]       trc_pc,
    output logic [XLEN-1:0]       trc_inst,
    output logic                  trc_wen,
    output logic [RIDX-1:0]       trc_wreg,
    output logic [XLEN-1:0]       trc_wdata
`endif
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, ir, mdr, reg_a, reg_b, target, alu_out, to_cnt;
    logic [XLEN-1:0] imm_ext, alu_b, alu_y, rd_a, rd_b, rf_wdata;
    logic [5:0]      op, funct;
    logic [RIDX-1:0] rf_waddr;
    logic [3:0]      alu_op;
    logic            xfer, alu_zero, halt_set, fault_set, rf_we;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign imm_ext  = sext16(ir[15:0]);
    assign xfer     = bus.mem_req && bus.mem_ack;
    assign rf_waddr = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
    assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

    mips_mc_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (ir[25:21]),
        .raddr_b   (ir[20:16]),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .rdata_a_c (rd_a),
        .rdata_b_c (rd_b)
    );

    alu u_alu (
        .alu_ctrl (alu_op),
        .a        (reg_a),
        .b        (alu_b),
        .result_c (alu_y),
        .alu_zero (alu_zero)
    );

    // Next-state, PC update and datapath strobes
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        halt_set  = 1'b0;
        fault_set = 1'b0;
        rf_we     = 1'b0;
        alu_op    = ALU_ADD;
        alu_b     = reg_b;
        case (state)
            FETCH: begin
                if (xfer) begin
                    state_nxt = DECODE;
                    pc_nxt    = pc + 32'd4;
                end
            end
            DECODE: begin
                if (!is_legal(op, funct)) begin
                    state_nxt = HALT;
                    halt_set  = 1'b1;
                    fault_set = 1'b1;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_SYSCALL) begin
                            state_nxt = HALT;
                            halt_set  = 1'b1;
                        end else begin
                            alu_op    = alu_ctrl_of(funct);
                            state_nxt = WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_b     = imm_ext;
                        state_nxt = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_b = imm_ext;
                        if (alu_y[1:0] != 2'b00) begin
                            state_nxt = HALT;
                            halt_set  = 1'b1;
                            fault_set = 1'b1;
                        end else begin
                            state_nxt = MEM;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op    = ALU_SUB;
                        state_nxt = FETCH;
                        if ((op == OP_BEQ) == alu_zero) pc_nxt = target;
                    end
                    default: begin
                        pc_nxt    = {pc[31:28], ir[25:0], 2'b00};
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (xfer) state_nxt = (op == OP_LW) ? WB : FETCH;
            end
            WB: begin
                rf_we     = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = HALT;
        endcase
        // Ack timeout overrides any other transition
        if ((ACK_TIMEOUT > 0) && bus.mem_req && !bus.mem_ack && (to_cnt == 32'(ACK_TIMEOUT - 1))) begin
            state_nxt = HALT;
            halt_set  = 1'b1;
            fault_set = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Datapath registers and registered memory-port outputs, driven from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            ir            <= '0;
            mdr           <= '0;
            reg_a         <= '0;
            reg_b         <= '0;
            target        <= '0;
            alu_out       <= '0;
            to_cnt        <= '0;
            halted        <= 1'b0;
            fault         <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            pc     <= pc_nxt;
            to_cnt <= (bus.mem_req && !bus.mem_ack) ? to_cnt + 32'd1 : '0;
            if (state == FETCH && xfer) ir <= bus.mem_rdata;
            if (state == MEM && xfer)   mdr <= bus.mem_rdata;
            if (state == DECODE) begin
                reg_a  <= rd_a;
                reg_b  <= rd_b;
                target <= pc + (imm_ext << 2);
            end
            if (state == EXEC) alu_out <= alu_y;
            if (halt_set)  halted <= 1'b1;
            if (fault_set) fault  <= 1'b1;
            bus.mem_req <= (state_nxt == FETCH) || (state_nxt == MEM);
            bus.mem_we  <= (state_nxt == MEM) && (op == OP_SW);
            if (state_nxt == FETCH) begin
                bus.mem_addr <= pc_nxt;
            end else if (state == EXEC && state_nxt == MEM) begin
                bus.mem_addr  <= alu_y;
                bus.mem_wdata <= reg_b;
            end
        end
    end

`ifdef MIPS_MC_TRACE_EN
    logic [XLEN-1:0] inst_pc;
    logic            retire_c;

    assign retire_c = ((state != FETCH) && (state != HALT) && (state_nxt == FETCH)) ||
                      ((state == EXEC) && halt_set && !fault_set);

    // Retire trace, one pulse on the last-state edge of each instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_pc   <= '0;
            trc_valid <= 1'b0;
            trc_pc    <= '0;
            trc_inst  <= '0;
            trc_wen   <= 1'b0;
            trc_wreg  <= '0;
            trc_wdata <= '0;
        end else begin
            if (state == FETCH && xfer) inst_pc <= pc;
            trc_valid <= retire_c;
            trc_pc    <= inst_pc;
            trc_inst  <= ir;
            trc_wen   <= rf_we && (rf_waddr != '0);
            trc_wreg  <= rf_we ? rf_waddr : '0;
            trc_wdata <= rf_we ? rf_wdata : '0;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: memory model with configurable ack latency,
// scoreboards for expected reads (address + cycle spacing) and expected writes.
`timescale 1ns/1ps
module tb_mips_mc_core;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_mc_core_if bus();
    mips_mc_core_if bus_to();
    logic halted, fault, halted_to, fault_to;

`ifdef MIPS_MC_TRACE_EN
    logic        trc_valid, trc_wen, trc_valid_to, trc_wen_to;
    logic [31:0] trc_pc, trc_inst, trc_wdata, trc_pc_to, trc_inst_to, trc_wdata_to;
    logic [4:0]  trc_wreg, trc_wreg_to;
`endif

    mips_mc_core #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted), .fault(fault)
`ifdef MIPS_MC_TRACE_EN
        , .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_inst(trc_inst),
        .trc_wen(trc_wen), .trc_wreg(trc_wreg), .trc_wdata(trc_wdata)
`endif
    );

    mips_mc_core #(.RESET_PC(32'h0000_0100), .ACK_TIMEOUT(8)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .bus(bus_to), .halted(halted_to), .fault(fault_to)
`ifdef MIPS_MC_TRACE_EN
        , .trc_valid(trc_valid_to), .trc_pc(trc_pc_to), .trc_inst(trc_inst_to),
        .trc_wen(trc_wen_to), .trc_wreg(trc_wreg_to), .trc_wdata(trc_wdata_to)
`endif
    );

    assign bus_to.mem_ack   = 1'b0;
    assign bus_to.mem_rdata = 32'h0;

    typedef struct { logic [31:0] addr; int delta; } rd_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    rd_t         exp_rd[$];
    wr_t         exp_wr[$];
    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          last_rd_cyc = 0;
    logic        prev_wait = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] r_inst(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_inst(input logic [31:0] tgt);
        return {OP_J, tgt[27:2]};
    endfunction

    task automatic push_rd(input logic [31:0] addr, input int delta);
        rd_t r;
        r.addr = addr; r.delta = delta;
        exp_rd.push_back(r);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        exp_wr.push_back(w);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: decides ack at the negedge, transfer happens on the following posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
            prev_wait = 1'b0;
        end else if (bus.mem_req) begin
            if (prev_wait) begin
                check("hold_addr", bus.mem_addr, prev_addr);
                check("hold_we", 32'(bus.mem_we), 32'(prev_we));
                if (prev_we) check("hold_wdata", bus.mem_wdata, prev_wdata);
            end
            if (wcnt >= lat) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
                prev_wait = 1'b0;
                bus.mem_rdata = mem[bus.mem_addr[9:2]];
                if (bus.mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected_queue", 32'(exp_wr.size()), 32'd1);
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("wr_addr", bus.mem_addr, w.addr);
                        check("wr_data", bus.mem_wdata, w.data);
                    end
                    mem[bus.mem_addr[9:2]] = bus.mem_wdata;
                end else begin
                    if (exp_rd.size() > 0) begin
                        rd_t r;
                        r = exp_rd.pop_front();
                        check("rd_addr", bus.mem_addr, r.addr);
                        if (r.delta >= 0) check("rd_cycles", 32'(cyc - last_rd_cyc), 32'(r.delta));
                    end
                    last_rd_cyc = cyc;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
                prev_wait = 1'b1;
                prev_addr = bus.mem_addr;
                prev_we = bus.mem_we;
                prev_wdata = bus.mem_wdata;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
            prev_wait = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = ILLEGAL;
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic reset_and_release(input string tag, input int l);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        lat = l;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_rd.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic wait_halt(input string tag, input logic exp_fault);
        int n;
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_req) n++;
        end
        check({tag, "_req_after_halt"}, 32'(n), 32'd0);
        check({tag, "_halted_sticky"}, 32'(halted), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;

        // Program A: ALU ops, stores, $0 write, bne/j/lw/beq at zero wait
        clear_mem();
        mem[8'h00] = i_inst(OP_ADDI, 0, 1, 5);
        mem[8'h01] = i_inst(OP_ADDI, 0, 2, -3);
        mem[8'h02] = r_inst(1, 2, 3, FN_ADD);
        mem[8'h03] = r_inst(2, 1, 4, FN_SLT);
        mem[8'h04] = i_inst(OP_SW, 0, 3, 32'h80);
        mem[8'h05] = i_inst(OP_SW, 0, 4, 32'h84);
        mem[8'h06] = r_inst(2, 1, 6, FN_SUB);
        mem[8'h07] = r_inst(1, 2, 7, FN_AND);
        mem[8'h08] = r_inst(1, 2, 8, FN_OR);
        mem[8'h09] = r_inst(1, 1, 0, FN_ADD);
        mem[8'h0A] = i_inst(OP_SW, 0, 6, 32'h88);
        mem[8'h0B] = i_inst(OP_SW, 0, 7, 32'h8C);
        mem[8'h0C] = i_inst(OP_SW, 0, 8, 32'h90);
        mem[8'h0D] = i_inst(OP_SW, 0, 0, 32'h94);
        mem[8'h0E] = i_inst(OP_BNE, 1, 1, 4);
        mem[8'h0F] = j_inst(32'h60);
        mem[8'h18] = i_inst(OP_LW, 0, 5, 32'h80);
        mem[8'h19] = i_inst(OP_SW, 0, 5, 32'h98);
        mem[8'h1A] = r_inst(1, 2, 9, FN_SLT);
        mem[8'h1B] = i_inst(OP_SW, 0, 9, 32'h9C);
        mem[8'h1C] = i_inst(OP_BEQ, 1, 1, -1);
        push_rd(32'h00, -1);
        for (int a = 4; a <= 32'h38; a += 4) push_rd(32'(a), 4);
        push_rd(32'h3C, 3);
        push_rd(32'h60, 3);
        push_rd(32'h80, 3);
        push_rd(32'h64, 2);
        push_rd(32'h68, 4);
        push_rd(32'h6C, 4);
        push_rd(32'h70, 4);
        for (int k = 0; k < 3; k++) push_rd(32'h70, 3);
        push_wr(32'h80, 32'd2);
        push_wr(32'h84, 32'd1);
        push_wr(32'h88, 32'hFFFF_FFF8);
        push_wr(32'h8C, 32'd5);
        push_wr(32'h90, 32'hFFFF_FFFD);
        push_wr(32'h94, 32'd0);
        push_wr(32'h98, 32'd2);
        push_wr(32'h9C, 32'd0);
        reset_and_release("rst_a", 0);

        // Ack-timeout instance: first fetch at its RESET_PC, faults after 8 unacked cycles
        n = 0;
        while (!bus_to.mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_first_addr", bus_to.mem_addr, 32'h100);
        n = 0;
        while (!halted_to && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'd8);
        check("to_fault", 32'(fault_to), 32'd1);
        check("to_req_drop", 32'(bus_to.mem_req), 32'd0);

        wait_drain("prog_a", 600);
        check("prog_a_not_halted", 32'(halted), 32'd0);

        // Program B: sw/lw with 3 wait states, then syscall
        rst_n = 1'b0;
        clear_mem();
        mem[8'h00] = j_inst(32'h40);
        mem[8'h10] = i_inst(OP_ADDI, 0, 3, 2);
        mem[8'h11] = i_inst(OP_SW, 0, 3, 8);
        mem[8'h12] = i_inst(OP_LW, 0, 5, 8);
        mem[8'h13] = i_inst(OP_SW, 0, 5, 32'h90);
        mem[8'h14] = {26'd0, FN_SYSCALL};
        push_rd(32'h00, -1);
        push_rd(32'h40, 6);
        push_rd(32'h44, 7);
        push_rd(32'h48, 10);
        push_rd(32'h08, 6);
        push_rd(32'h4C, 5);
        push_rd(32'h50, 10);
        push_wr(32'h08, 32'd2);
        push_wr(32'h90, 32'd2);
        reset_and_release("rst_b", 3);
        wait_drain("prog_b", 800);
        wait_halt("syscall", 1'b0);

        // Program C: illegal opcode
        rst_n = 1'b0;
        clear_mem();
        push_rd(32'h00, -1);
        reset_and_release("rst_c", 0);
        wait_halt("illegal", 1'b1);
        wait_drain("prog_c", 10);

        // Program D: misaligned lw
        rst_n = 1'b0;
        clear_mem();
        mem[8'h00] = i_inst(OP_LW, 0, 5, 6);
        push_rd(32'h00, -1);
        reset_and_release("rst_d", 0);
        wait_halt("misaligned", 1'b1);
        wait_drain("prog_d", 10);

        // Program E: reset during an sw wait state drops req at once, restart fetches RESET_PC
        rst_n = 1'b0;
        clear_mem();
        mem[8'h00] = i_inst(OP_SW, 0, 0, 32'h80);
        push_rd(32'h00, -1);
        reset_and_release("rst_e", 5);
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("sw_wait_seen", 32'(bus.mem_req && bus.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_req_drop", 32'(bus.mem_req), 32'd0);
        check("async_we_drop", 32'(bus.mem_we), 32'd0);
        clear_mem();
        mem[8'h00] = {26'd0, FN_SYSCALL};
        push_rd(32'h00, -1);
        reset_and_release("rst_e2", 0);
        wait_halt("restart", 1'b0);
        wait_drain("prog_e", 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
